vscale_hasti_arbiter: RTL and testbench
=======================================

Name: vscale_hasti_arbiter

Overview:
- Two-master to one-slave AHB-Lite (HASTI) arbiter. It lets the core's instruction and data bridges share one memory/peripheral port.
- Sits between the imem/dmem bridge outputs (master 0 = imem, master 1 = dmem) and a single slave.
- Each master has a one-entry address buffer, so a master that loses arbitration is stalled through its own hready. It never sees a dropped transfer.
- Zero added latency when only one master is active.

Parameters:
- ARB_RR, 1, 1 = round-robin between masters; 0 = fixed priority, master 1 (dmem) always wins.

Ports:
- hclk  input  1  bus clock
- hresetn  input  1  asynchronous active-low reset
- m_haddr  input  64  master address; master i at [32i+31:32i]
- m_hwrite  input  2  master write flag, bit i
- m_hsize  input  6  master size, [3i+2:3i]
- m_htrans  input  4  master htrans, [2i+1:2i]
- m_hwdata  input  64  master write data
- m_hrdata  output  32  read data, broadcast to both masters
- m_hready  output  2  per-master hready
- m_hresp  output  2  per-master hresp
- s_haddr  output  32  slave address
- s_hwrite  output  1  slave write flag
- s_hsize  output  3  slave size
- s_hburst  output  3  constant HASTI_BURST_SINGLE
- s_hmastlock  output  1  constant 0
- s_hprot  output  4  constant HASTI_NO_PROT
- s_htrans  output  2  slave htrans
- s_hwdata  output  32  slave write data
- s_hrdata  input  32  slave read data
- s_hready  input  1  slave hready
- s_hresp  input  1  slave hresp

Behaviour:
- State:
  - per master i: pend_valid[i] plus pend_addr/write/size[i]
  - aown_valid/aown: address phase presented but not accepted (s_hready low)
  - down_valid/down: data-phase owner
  - rr_last
- Reset (async on hresetn low):
  - pend_valid = 0, aown_valid = 0, down_valid = 0, rr_last = 1 (master 0 wins first tie)
  - Outputs in reset: m_hready = 2'b11, m_hresp = 0, s_htrans = IDLE
- m_hready[i]:
  - 0 if pend_valid[i]
  - else s_hready if down_valid and down == i
  - else 1
- Master accept: master i presents a transfer when m_htrans[i] is NONSEQ/SEQ and m_hready[i] = 1.
- Candidate source per master: pend_valid[i] ? buffer : accepted live transfer. IDLE/BUSY is never forwarded; SEQ is forwarded as NONSEQ.
- Grant selection:
  - If aown_valid, grant = aown (address held stable while s_hready low).
  - Else if one candidate, grant = that master.
  - Else (two candidates) grant by ARB_RR: the master != rr_last wins. With ARB_RR = 0, master 1 wins.
- Slave address phase:
  - s_haddr/s_hwrite/s_hsize come from the granted source.
  - s_htrans = NONSEQ if any candidate, else IDLE.
- Capture into buffer: a live transfer accepted from master i goes into pend[i] if either:
  - i is not granted, or
  - i is granted but s_hready = 0.
- Clear buffer: pend_valid[i] clears when the buffered transfer is granted and s_hready = 1.
- Owner updates, on s_hready = 1 with NONSEQ issued:
  - down <= grant, down_valid <= 1, rr_last <= grant
- On s_hready = 1 with IDLE issued: down_valid <= 0.
- On s_hready = 0 with NONSEQ issued: aown_valid <= 1, aown <= grant. Cleared on the next s_hready = 1.
- Data phase:
  - s_hwdata = m_hwdata[down].
  - m_hrdata = s_hrdata.
  - m_hresp[i] = s_hresp when down_valid and down == i, else 0.
  - The two-cycle ERROR passes through unchanged.
- Ordering: at most one buffered transfer per master. A buffered master is stalled (m_hready = 0), so its wdata stays held until its slave data phase completes.
- Simultaneous accept and pend clear for the same master cannot occur (m_hready = 0 while pend_valid).
- Reset mid-transfer: all buffers are discarded and no completion is reported. Masters are reset by the same hresetn.
- ARB_RR = 0 can starve master 0. This is accepted by design.

Decomposition:
- vscale_hasti_constants.vh holds HASTI_TRANS_IDLE/BUSY/NONSEQ/SEQ, HASTI_SIZE_*, HASTI_BURST_SINGLE, HASTI_NO_PROT and a new HASTI_MASTER_IMEM = 0 / HASTI_MASTER_DMEM = 1.
- One sub-module, vscale_hasti_arb_input_stage, instantiated twice. It contains:
  - the pend buffer
  - m_hready/m_hresp generation
  - candidate output
- The top level holds grant logic and the aown/down/rr_last registers.

Test Plan:
- m0 reads 0x100, 0x104, 0x108 back-to-back; m1 idle; s_hready = 1 → s_haddr equals m0 address in the same cycle, m0_hready stays 1, each m0 read returns s_hrdata one cycle after its address.
- After reset, m0 and m1 both NONSEQ at cycle t (m0 0x200, m1 0x8000) → s_haddr = 0x200 at t, 0x8000 at t+1. m1_hready = 0 at t+1 and 1 at t+2; next tie goes to m0.
- m1 write 0xDEADBEEF to 0x8000 with s_hready held low 3 cycles during its data phase → s_hwdata = 0xDEADBEEF for all 4 cycles. m1_hready = 0 for 3 cycles. A m0 request in that window is buffered and s_haddr stays constant.
- s_hready = 0 while m0 address 0x300 is on the slave, m1 requests → s_haddr stays 0x300 until s_hready = 1; m1 is served the next cycle.
- Slave ERROR on m0 read (s_hresp = 1 with s_hready 0 then 1) → m0_hresp = 1 for both cycles, m1_hresp = 0, m1 traffic unaffected.
- hresetn low while m1 pend_valid = 1 and s_hready = 0 → immediately m_hready = 2'b11, s_htrans = IDLE; after release the first transfer issues with no stale address.
- ARB_RR = 0, both masters requesting continuously → every grant goes to m1; m0_hready stays 0 while its request is buffered.

Source files
------------

// File: rtl/vscale_hasti_arbiter_pkg.sv
// rtl/vscale_hasti_arbiter_pkg.sv - HASTI bus constants, request record and helpers
// Shared by the arbiter top, its input stages and the bench.
package vscale_hasti_arbiter_pkg;

  localparam logic [1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [1:0] HASTI_TRANS_BUSY   = 2'd1;
  localparam logic [1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HASTI_TRANS_SEQ    = 2'd3;

  localparam logic [2:0] HASTI_SIZE_BYTE     = 3'd0;
  localparam logic [2:0] HASTI_SIZE_HALFWORD = 3'd1;
  localparam logic [2:0] HASTI_SIZE_WORD     = 3'd2;

  localparam logic [2:0] HASTI_BURST_SINGLE = 3'd0;
  localparam logic [3:0] HASTI_NO_PROT      = 4'd0;

  localparam logic HASTI_MASTER_IMEM = 1'b0;
  localparam logic HASTI_MASTER_DMEM = 1'b1;

  // Address-phase attributes that get forwarded to the slave.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } hasti_req_t;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never reach the slave.
  function automatic logic hasti_trans_active(input logic [1:0] trans);
    return (trans == HASTI_TRANS_NONSEQ) || (trans == HASTI_TRANS_SEQ);
  endfunction

endpackage

// File: rtl/vscale_hasti_arbiter_if.sv
// rtl/vscale_hasti_arbiter_if.sv - two-master / one-slave HASTI signal bundle
// Master-side vectors pack master i at bit slice i.
// slave  : the arbiter's view (takes master requests, drives the slave port)
// master : the environment's view (drives master requests and slave responses)
interface vscale_hasti_arbiter_if;
  logic [63:0] m_haddr;
  logic [1:0]  m_hwrite;
  logic [5:0]  m_hsize;
  logic [3:0]  m_htrans;
  logic [63:0] m_hwdata;
  logic [31:0] m_hrdata;
  logic [1:0]  m_hready;
  logic [1:0]  m_hresp;
  logic [31:0] s_haddr;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [2:0]  s_hburst;
  logic        s_hmastlock;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;
  logic [31:0] s_hwdata;
  logic [31:0] s_hrdata;
  logic        s_hready;
  logic        s_hresp;

  modport slave (
    input  m_haddr, m_hwrite, m_hsize, m_htrans, m_hwdata,
    input  s_hrdata, s_hready, s_hresp,
    output m_hrdata, m_hready, m_hresp,
    output s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans, s_hwdata
  );

  modport master (
    output m_haddr, m_hwrite, m_hsize, m_htrans, m_hwdata,
    output s_hrdata, s_hready, s_hresp,
    input  m_hrdata, m_hready, m_hresp,
    input  s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans, s_hwdata
  );
endinterface

// File: rtl/vscale_hasti_arb_input_stage.sv
// rtl/vscale_hasti_arb_input_stage.sv - per-master one-entry address buffer and handshake
// Ports: hclk/hresetn; master address phase in (haddr, hwrite, hsize, htrans);
// hready/hresp back to the master; is_down (this master owns the slave data
// phase), granted (this master wins the slave address phase now), s_hready/s_hresp
// from the slave; cand_valid/cand = this master's request offered for arbitration.
module vscale_hasti_arb_input_stage
  import vscale_hasti_arbiter_pkg::*;
(
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  output logic        hready,
  output logic        hresp,
  input  logic        is_down,
  input  logic        granted,
  input  logic        s_hready,
  input  logic        s_hresp,
  output logic        cand_valid,
  output hasti_req_t  cand
);

  logic       pend_valid;
  hasti_req_t pend;
  hasti_req_t live;
  logic       live_valid;

  // A buffered master is stalled until its request leaves for the slave.
  assign hready = pend_valid ? 1'b0 : (is_down ? s_hready : 1'b1);
  assign hresp  = is_down & s_hresp;

  assign live = '{addr: haddr, write: hwrite, size: hsize};
  // Gating with hresetn keeps the slave port IDLE while reset is held.
  assign live_valid = hresetn & hready & hasti_trans_active(htrans);

  assign cand_valid = pend_valid | live_valid;
  assign cand       = pend_valid ? pend : live;

  // Accept and clear never coincide: hready is low whenever pend_valid is set.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pend_valid <= 1'b0;
      pend       <= '0;
    end else if (pend_valid) begin
      if (granted && s_hready) pend_valid <= 1'b0;
    end else if (live_valid && !(granted && s_hready)) begin
      pend_valid <= 1'b1;
      pend       <= live;
    end
  end

endmodule

// File: rtl/vscale_hasti_arbiter.sv
// rtl/vscale_hasti_arbiter.sv - two-master (imem=0, dmem=1) to one-slave HASTI arbiter
// Ports: hclk, hresetn (async active-low), bus (slave modport: master request
// vectors in, per-master hready/hresp and broadcast hrdata out, slave port out).
// ARB_RR = 1 alternates on ties, ARB_RR = 0 always favours dmem.
module vscale_hasti_arbiter
  import vscale_hasti_arbiter_pkg::*;
#(
  parameter int ARB_RR = 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  vscale_hasti_arbiter_if.slave bus
);

  logic [1:0] cand_valid;
  hasti_req_t cand [2];
  logic       aown_valid, aown;
  logic       down_valid, down;
  logic       rr_last;
  logic       grant;
  logic       any_cand;

  vscale_hasti_arb_input_stage u_in0 (
    .hclk(hclk), .hresetn(hresetn),
    .haddr(bus.m_haddr[31:0]), .hwrite(bus.m_hwrite[0]),
    .hsize(bus.m_hsize[2:0]), .htrans(bus.m_htrans[1:0]),
    .hready(bus.m_hready[0]), .hresp(bus.m_hresp[0]),
    .is_down(down_valid && (down == HASTI_MASTER_IMEM)),
    .granted(any_cand && (grant == HASTI_MASTER_IMEM)),
    .s_hready(bus.s_hready), .s_hresp(bus.s_hresp),
    .cand_valid(cand_valid[0]), .cand(cand[0])
  );

  vscale_hasti_arb_input_stage u_in1 (
    .hclk(hclk), .hresetn(hresetn),
    .haddr(bus.m_haddr[63:32]), .hwrite(bus.m_hwrite[1]),
    .hsize(bus.m_hsize[5:3]), .htrans(bus.m_htrans[3:2]),
    .hready(bus.m_hready[1]), .hresp(bus.m_hresp[1]),
    .is_down(down_valid && (down == HASTI_MASTER_DMEM)),
    .granted(any_cand && (grant == HASTI_MASTER_DMEM)),
    .s_hready(bus.s_hready), .s_hresp(bus.s_hresp),
    .cand_valid(cand_valid[1]), .cand(cand[1])
  );

  assign any_cand = |cand_valid;

  // A stalled slave address phase keeps its owner so the address stays stable.
  always_comb begin
    grant = HASTI_MASTER_IMEM;
    if (aown_valid)                grant = aown;
    else if (cand_valid == 2'b10)  grant = HASTI_MASTER_DMEM;
    else if (cand_valid == 2'b11)  grant = (ARB_RR != 0) ? ~rr_last : HASTI_MASTER_DMEM;
  end

  assign bus.s_haddr     = cand[grant].addr;
  assign bus.s_hwrite    = cand[grant].write;
  assign bus.s_hsize     = cand[grant].size;
  assign bus.s_htrans    = any_cand ? HASTI_TRANS_NONSEQ : HASTI_TRANS_IDLE;
  assign bus.s_hburst    = HASTI_BURST_SINGLE;
  assign bus.s_hmastlock = 1'b0;
  assign bus.s_hprot     = HASTI_NO_PROT;
  assign bus.s_hwdata    = down ? bus.m_hwdata[63:32] : bus.m_hwdata[31:0];
  assign bus.m_hrdata    = bus.s_hrdata;

  // rr_last starts at dmem so imem wins the first tie after reset.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      aown_valid <= 1'b0;
      aown       <= HASTI_MASTER_IMEM;
      down_valid <= 1'b0;
      down       <= HASTI_MASTER_IMEM;
      rr_last    <= HASTI_MASTER_DMEM;
    end else if (bus.s_hready) begin
      aown_valid <= 1'b0;
      down_valid <= any_cand;
      if (any_cand) begin
        down    <= grant;
        rr_last <= grant;
      end
    end else if (any_cand) begin
      aown_valid <= 1'b1;
      aown       <= grant;
    end
  end

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// tb/tb_vscale_hasti_arbiter.sv - randomized bench for both arbitration policies
module tb_vscale_hasti_arbiter;
  import vscale_hasti_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } txn_t;

  // Instance 0 runs round-robin, instance 1 fixed dmem priority.
  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int RR = (g == 0) ? 1 : 0;

    vscale_hasti_arbiter_if bus ();
    vscale_hasti_arbiter #(.ARB_RR(RR)) dut (.hclk(clk), .hresetn(rst_n), .bus(bus));

    initial begin : run
      // Master-side view of what each bridge is currently driving.
      txn_t        live [2];
      logic [1:0]  trans [2];
      logic [31:0] wdata [2];
      // Transaction-level model: requests waiting for the slave, a slave
      // address phase held by a stalled slave, the data-phase owner.
      txn_t        waiting [2];
      bit          wait_v [2];
      bit          held_v;
      int          held_m;
      bit          own_v;
      int          own_m;
      int          last_win;
      bit          exp_rdy [2];
      bit          avail [2];
      txn_t        req [2];
      bit          any;
      int          win;
      bit          s_rdy, s_rsp, err_stage;
      logic [31:0] rdata;
      int          r;
      string       pfx;

      pfx = $sformatf("rr%0d", RR);
      wait_v = '{0, 0}; held_v = 0; held_m = 0; own_v = 0; own_m = 0; last_win = 1;
      exp_rdy = '{1, 1}; avail = '{0, 0}; any = 0; win = 0; err_stage = 0;
      s_rdy = 1; s_rsp = 0; rdata = '0;
      for (int i = 0; i < 2; i++) begin
        live[i] = '0; trans[i] = HASTI_TRANS_IDLE; wdata[i] = '0; waiting[i] = '0; req[i] = '0;
      end

      while (!done) begin
        bus.m_haddr  = {live[1].addr, live[0].addr};
        bus.m_hwrite = {live[1].write, live[0].write};
        bus.m_hsize  = {live[1].size, live[0].size};
        bus.m_htrans = {trans[1], trans[0]};
        bus.m_hwdata = {wdata[1], wdata[0]};
        bus.s_hready = s_rdy;
        bus.s_hresp  = s_rsp;
        bus.s_hrdata = rdata;

        @(posedge clk);
        if (rst_n) begin
          // Winner leaves if the slave took it; every other offered request waits.
          for (int i = 0; i < 2; i++) begin
            if (avail[i]) begin
              if (i == win && s_rdy) wait_v[i] = 0;
              else begin wait_v[i] = 1; waiting[i] = req[i]; end
            end
          end
          if (s_rdy) begin
            held_v = 0;
            own_v  = any;
            if (any) begin own_m = win; last_win = win; end
          end else if (any) begin
            held_v = 1; held_m = win;
          end
        end

        #1;
        for (int i = 0; i < 2; i++) begin
          if (exp_rdy[i]) begin
            r = int'($urandom % 8);
            trans[i] = (r < 2) ? HASTI_TRANS_IDLE : (r == 2) ? HASTI_TRANS_BUSY :
                       ((r % 2) != 0) ? HASTI_TRANS_NONSEQ : HASTI_TRANS_SEQ;
            live[i].addr  = $urandom;
            live[i].write = 1'($urandom % 2);
            live[i].size  = 3'($urandom % 8);
            wdata[i]      = $urandom;
          end
        end
        if (err_stage) begin
          s_rsp = 1; s_rdy = 1; err_stage = 0;
        end else if (own_v && ($urandom % 10 == 0)) begin
          s_rsp = 1; s_rdy = 0; err_stage = 1;
        end else begin
          s_rsp = 0; s_rdy = ($urandom % 4 != 0);
        end
        rdata = $urandom;
        bus.m_haddr  = {live[1].addr, live[0].addr};
        bus.m_hwrite = {live[1].write, live[0].write};
        bus.m_hsize  = {live[1].size, live[0].size};
        bus.m_htrans = {trans[1], trans[0]};
        bus.m_hwdata = {wdata[1], wdata[0]};
        bus.s_hready = s_rdy;
        bus.s_hresp  = s_rsp;
        bus.s_hrdata = rdata;

        #4;
        if (!rst_n) begin
          wait_v = '{0, 0}; held_v = 0; own_v = 0; last_win = 1; err_stage = 0;
          exp_rdy = '{1, 1}; avail = '{0, 0}; any = 0;
          check({pfx, " reset m_hready"}, 64'(bus.m_hready), 64'd3);
          check({pfx, " reset m_hresp"}, 64'(bus.m_hresp), 64'd0);
          check({pfx, " reset s_htrans"}, 64'(bus.s_htrans), 64'(HASTI_TRANS_IDLE));
        end else begin
          for (int i = 0; i < 2; i++) begin
            exp_rdy[i] = wait_v[i] ? 1'b0 : ((own_v && own_m == i) ? s_rdy : 1'b1);
            avail[i]   = wait_v[i] || (exp_rdy[i] &&
                         (trans[i] == HASTI_TRANS_NONSEQ || trans[i] == HASTI_TRANS_SEQ));
            req[i]     = wait_v[i] ? waiting[i] : live[i];
          end
          any = avail[0] || avail[1];
          if (held_v) win = held_m;
          else if (avail[0] && avail[1]) win = (RR != 0) ? 1 - last_win : 1;
          else win = avail[1] ? 1 : 0;

          check({pfx, " m_hready"}, 64'(bus.m_hready), 64'({exp_rdy[1], exp_rdy[0]}));
          check({pfx, " m_hresp"}, 64'(bus.m_hresp),
                64'({own_v && own_m == 1 && s_rsp, own_v && own_m == 0 && s_rsp}));
          check({pfx, " s_htrans"}, 64'(bus.s_htrans),
                64'(any ? HASTI_TRANS_NONSEQ : HASTI_TRANS_IDLE));
          check({pfx, " m_hrdata"}, 64'(bus.m_hrdata), 64'(rdata));
          check({pfx, " s_hburst"}, 64'(bus.s_hburst), 64'd0);
          check({pfx, " s_hprot/lock"}, 64'({bus.s_hprot, bus.s_hmastlock}), 64'd0);
          if (any) begin
            check({pfx, " s_haddr"}, 64'(bus.s_haddr), 64'(req[win].addr));
            check({pfx, " s_hwrite"}, 64'(bus.s_hwrite), 64'(req[win].write));
            check({pfx, " s_hsize"}, 64'(bus.s_hsize), 64'(req[win].size));
          end
          if (own_v)
            check({pfx, " s_hwdata"}, 64'(bus.s_hwdata), 64'(wdata[own_m]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (1500) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (1500) @(posedge clk);
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
